// File: rtl/inst_trace_buffer_pkg.sv
// Shared constants for the retire-trace recorder: widths, opcodes, states, classes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package inst_trace_buffer_pkg;

  localparam int INST_WIDTH     = 32;
  localparam int REG_DATA_WIDTH = 32;

  // RV32I major opcodes used for retire classification
  localparam logic [6:0] R_FORMAT_OPCODE     = 7'b0110011;
  localparam logic [6:0] B_FORMAT_OPCODE     = 7'b1100011;
  localparam logic [6:0] J_FORMAT_OPCODE     = 7'b1101111;
  localparam logic [6:0] I_FORMAT_OPCODE     = 7'b0010011;
  localparam logic [6:0] LOAD_FORMAT_OPCODE  = 7'b0000011;
  localparam logic [6:0] STORE_FORMAT_OPCODE = 7'b0100011;

  // Recorder states, visible on the state port
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARMED  = 3'd1;
  localparam logic [2:0] ST_POST   = 3'd2;
  localparam logic [2:0] ST_FROZEN = 3'd3;
  localparam logic [2:0] ST_DUMP   = 3'd4;

  localparam int NUM_CLASSES = 7;

  typedef enum logic [2:0] {
    CLS_R, CLS_B, CLS_J, CLS_I, CLS_LD, CLS_ST, CLS_OTHER
  } op_class_e;

  // One trace entry is {pc, inst, wdata}
  function automatic int trace_entry_width(input int pc_width);
    return pc_width + INST_WIDTH + REG_DATA_WIDTH;
  endfunction

  function automatic op_class_e classify(input logic [6:0] opcode);
    op_class_e c;
    case (opcode)
      R_FORMAT_OPCODE:     c = CLS_R;
      B_FORMAT_OPCODE:     c = CLS_B;
      J_FORMAT_OPCODE:     c = CLS_J;
      I_FORMAT_OPCODE:     c = CLS_I;
      LOAD_FORMAT_OPCODE:  c = CLS_LD;
      STORE_FORMAT_OPCODE: c = CLS_ST;
      default:             c = CLS_OTHER;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/inst_trace_buffer_trace_mem.sv
// Trace storage: DEPTH x WIDTH flop array, no reset.
// Latency: write lands on the clock edge, read is combinational.
// Backpressure: none; the owner never reads and writes in the same phase.
module trace_mem
  import inst_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = trace_entry_width(32)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store one entry per write strobe
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_trace_buffer.sv
// Retire-trace recorder: circular history, opcode-class counters, PC trigger, oldest-first dump.
// Latency: dump_valid one cycle after dump_start; one entry per cycle while dump_ready is high.
// Backpressure: dump_* held stable while dump_valid && !dump_ready; retires never stall.
module inst_trace_buffer
  import inst_trace_buffer_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      retire_valid,
  input  logic [PC_WIDTH-1:0]       retire_pc,
  input  logic [INST_WIDTH-1:0]     retire_inst,
  input  logic [REG_DATA_WIDTH-1:0] retire_wdata,
  input  logic                      arm,
  input  logic                      trig_en,
  input  logic [PC_WIDTH-1:0]       trig_pc,
  input  logic                      dump_start,
  input  logic                      dump_ready,
  output logic                      dump_valid,
  output logic [PC_WIDTH-1:0]       dump_pc,
  output logic [INST_WIDTH-1:0]     dump_inst,
  output logic [REG_DATA_WIDTH-1:0] dump_wdata,
  output logic                      dump_last,
  output logic [2:0]                state,
  output logic [$clog2(DEPTH):0]    fill,
  output logic                      trig_hit,
  output logic [CNT_WIDTH-1:0]      cnt_r,
  output logic [CNT_WIDTH-1:0]      cnt_b,
  output logic [CNT_WIDTH-1:0]      cnt_j,
  output logic [CNT_WIDTH-1:0]      cnt_i,
  output logic [CNT_WIDTH-1:0]      cnt_ld,
  output logic [CNT_WIDTH-1:0]      cnt_st,
  output logic [CNT_WIDTH-1:0]      cnt_other
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int EW = trace_entry_width(PC_WIDTH);
  localparam logic [FW-1:0]        FILL_FULL = FW'(DEPTH);
  localparam logic [FW-1:0]        FW_ONE    = FW'(1);
  localparam logic [AW-1:0]        AW_ONE    = AW'(1);
  localparam logic [FW-1:0]        POST_INIT = FW'(POST_TRIG);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic [2:0]                state_q, state_d;
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]             fill_q, fill_d, post_cnt_q, post_cnt_d;
  // Entries still to present after the one currently on the dump port
  logic [FW-1:0]             remain_q, remain_d;
  logic                      trig_hit_q, trig_hit_d;
  logic [CNT_WIDTH-1:0]      cnt_q [NUM_CLASSES];
  logic [CNT_WIDTH-1:0]      cnt_d [NUM_CLASSES];
  logic                      dump_valid_q, dump_valid_d, dump_last_q, dump_last_d;
  logic [PC_WIDTH-1:0]       dump_pc_q, dump_pc_d;
  logic [INST_WIDTH-1:0]     dump_inst_q, dump_inst_d;
  logic [REG_DATA_WIDTH-1:0] dump_wdata_q, dump_wdata_d;

  logic          rec, load, mem_we;
  logic [AW-1:0] mem_raddr;
  logic [EW-1:0] mem_rdata;
  op_class_e     cls;

  assign cls    = classify(retire_inst[6:0]);
  assign mem_we = rec;

  trace_mem #(.DEPTH(DEPTH), .WIDTH(EW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata ({retire_pc, retire_inst, retire_wdata}),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Next-state: arm/clear, record + trigger, post-trigger countdown, dump sequencing
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_d       = fill_q;
    post_cnt_d   = post_cnt_q;
    remain_d     = remain_q;
    trig_hit_d   = trig_hit_q;
    cnt_d        = cnt_q;
    dump_valid_d = dump_valid_q;
    dump_last_d  = dump_last_q;
    dump_pc_d    = dump_pc_q;
    dump_inst_d  = dump_inst_q;
    dump_wdata_d = dump_wdata_q;
    rec          = 1'b0;
    load         = 1'b0;
    mem_raddr    = rd_ptr_q;

    if (arm && state_q != ST_DUMP) begin
      // Arming wins over a same-cycle retire: nothing is recorded
      state_d    = ST_ARMED;
      wr_ptr_d   = '0;
      fill_d     = '0;
      post_cnt_d = '0;
      trig_hit_d = 1'b0;
      cnt_d      = '{default: '0};
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (retire_valid) begin
            rec = 1'b1;
            if (trig_en && retire_pc == trig_pc) begin
              trig_hit_d = 1'b1;
              if (POST_TRIG == 0) begin
                state_d = ST_FROZEN;
              end else begin
                state_d    = ST_POST;
                post_cnt_d = POST_INIT;
              end
            end
          end
        end
        ST_POST: begin
          if (retire_valid) begin
            rec        = 1'b1;
            post_cnt_d = post_cnt_q - FW_ONE;
            if (post_cnt_q == FW_ONE) state_d = ST_FROZEN;
          end
        end
        ST_FROZEN: begin
          if (dump_start && fill_q != '0) begin
            // A wrapped buffer starts at the oldest slot, which is the next write slot
            state_d     = ST_DUMP;
            load        = 1'b1;
            mem_raddr   = (fill_q == FILL_FULL) ? wr_ptr_q : '0;
            remain_d    = fill_q - FW_ONE;
            dump_last_d = (fill_q == FW_ONE);
          end
        end
        ST_DUMP: begin
          if (dump_valid_q && dump_ready) begin
            if (dump_last_q) begin
              state_d      = ST_FROZEN;
              dump_valid_d = 1'b0;
              dump_last_d  = 1'b0;
            end else begin
              load        = 1'b1;
              remain_d    = remain_q - FW_ONE;
              dump_last_d = (remain_q == FW_ONE);
            end
          end
        end
        default: ;
      endcase

      if (rec) begin
        wr_ptr_d = wr_ptr_q + AW_ONE;
        if (fill_q != FILL_FULL) fill_d = fill_q + FW_ONE;
        if (cnt_q[cls] != '1) cnt_d[cls] = cnt_q[cls] + CNT_ONE;
      end

      if (load) begin
        dump_valid_d = 1'b1;
        {dump_pc_d, dump_inst_d, dump_wdata_d} = mem_rdata;
        rd_ptr_d = mem_raddr + AW_ONE;
      end
    end
  end

  // Control and dump-port registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      post_cnt_q   <= '0;
      remain_q     <= '0;
      trig_hit_q   <= 1'b0;
      cnt_q        <= '{default: '0};
      dump_valid_q <= 1'b0;
      dump_last_q  <= 1'b0;
      dump_pc_q    <= '0;
      dump_inst_q  <= '0;
      dump_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      post_cnt_q   <= post_cnt_d;
      remain_q     <= remain_d;
      trig_hit_q   <= trig_hit_d;
      cnt_q        <= cnt_d;
      dump_valid_q <= dump_valid_d;
      dump_last_q  <= dump_last_d;
      dump_pc_q    <= dump_pc_d;
      dump_inst_q  <= dump_inst_d;
      dump_wdata_q <= dump_wdata_d;
    end
  end

  assign state      = state_q;
  assign fill       = fill_q;
  assign trig_hit   = trig_hit_q;
  assign dump_valid = dump_valid_q;
  assign dump_last  = dump_last_q;
  assign dump_pc    = dump_pc_q;
  assign dump_inst  = dump_inst_q;
  assign dump_wdata = dump_wdata_q;
  assign cnt_r      = cnt_q[CLS_R];
  assign cnt_b      = cnt_q[CLS_B];
  assign cnt_j      = cnt_q[CLS_J];
  assign cnt_i      = cnt_q[CLS_I];
  assign cnt_ld     = cnt_q[CLS_LD];
  assign cnt_st     = cnt_q[CLS_ST];
  assign cnt_other  = cnt_q[CLS_OTHER];

endmodule

// File: tb/tb_inst_trace_buffer.sv
// Bench for inst_trace_buffer (DEPTH=8, POST_TRIG=2, CNT_WIDTH=4): queue-based reference
// model checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_inst_trace_buffer;

  localparam int DEPTH     = 8;
  localparam int POST_TRIG = 2;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_pc = '0, retire_inst = '0, retire_wdata = '0;
  logic        arm = 1'b0, trig_en = 1'b0, dump_start = 1'b0, dump_ready = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        dump_valid, dump_last, trig_hit;
  logic [31:0] dump_pc, dump_inst, dump_wdata;
  logic [2:0]  state;
  logic [3:0]  fill;
  logic [CNT_W-1:0] cnt_r, cnt_b, cnt_j, cnt_i, cnt_ld, cnt_st, cnt_other;

  always #5 clk = ~clk;

  inst_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .PC_WIDTH(32), .CNT_WIDTH(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_inst(retire_inst), .retire_wdata(retire_wdata), .arm(arm), .trig_en(trig_en),
    .trig_pc(trig_pc), .dump_start(dump_start), .dump_ready(dump_ready),
    .dump_valid(dump_valid), .dump_pc(dump_pc), .dump_inst(dump_inst), .dump_wdata(dump_wdata),
    .dump_last(dump_last), .state(state), .fill(fill), .trig_hit(trig_hit),
    .cnt_r(cnt_r), .cnt_b(cnt_b), .cnt_j(cnt_j), .cnt_i(cnt_i), .cnt_ld(cnt_ld),
    .cnt_st(cnt_st), .cnt_other(cnt_other)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; logic [31:0] wdata; } ent_t;
  ent_t hist[$];
  ent_t m_dump[$];
  int   m_state, m_post;
  int   m_cnt[7];
  bit   m_trig, m_dvalid;

  // 0=R 1=B 2=J 3=I 4=LD 5=ST 6=other
  function automatic int cls_of(input logic [31:0] inst);
    case (inst[6:0])
      7'h33:   return 0;
      7'h63:   return 1;
      7'h6F:   return 2;
      7'h13:   return 3;
      7'h03:   return 4;
      7'h23:   return 5;
      default: return 6;
    endcase
  endfunction

  task automatic m_record();
    ent_t e;
    int   c;
    e.pc = retire_pc; e.inst = retire_inst; e.wdata = retire_wdata;
    hist.push_back(e);
    if (hist.size() > DEPTH) void'(hist.pop_front());
    c = cls_of(retire_inst);
    if (m_cnt[c] < CNT_MAX) m_cnt[c]++;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_post = 0; m_trig = 0; m_dvalid = 0;
      hist.delete(); m_dump.delete();
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else if (arm && m_state != 4) begin
      m_state = 1; m_post = 0; m_trig = 0;
      hist.delete();
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      case (m_state)
        1: if (retire_valid) begin
             m_record();
             if (trig_en && retire_pc == trig_pc) begin
               m_trig = 1;
               if (POST_TRIG == 0) m_state = 3;
               else begin m_state = 2; m_post = POST_TRIG; end
             end
           end
        2: if (retire_valid) begin
             m_record();
             m_post--;
             if (m_post == 0) m_state = 3;
           end
        3: if (dump_start && hist.size() > 0) begin
             m_dump = hist; m_dvalid = 1; m_state = 4;
           end
        4: if (m_dvalid && dump_ready) begin
             void'(m_dump.pop_front());
             if (m_dump.size() == 0) begin m_dvalid = 0; m_state = 3; end
           end
        default: ;
      endcase
    end
  end

  // ---------------- per-cycle compare + transfer capture ----------------
  logic [31:0] got_pc[$];
  bit          got_last[$];
  bit          stall_prev = 0;
  logic [31:0] prev_pc, prev_inst, prev_wdata;
  logic        prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      check("state", state, m_state);
      check("fill", fill, hist.size());
      check("trig_hit", trig_hit, m_trig);
      check("cnt_r", cnt_r, m_cnt[0]);
      check("cnt_b", cnt_b, m_cnt[1]);
      check("cnt_j", cnt_j, m_cnt[2]);
      check("cnt_i", cnt_i, m_cnt[3]);
      check("cnt_ld", cnt_ld, m_cnt[4]);
      check("cnt_st", cnt_st, m_cnt[5]);
      check("cnt_other", cnt_other, m_cnt[6]);
      check("dump_valid", dump_valid, m_dvalid);
      if (m_dvalid && m_dump.size() > 0) begin
        check("dump_pc", dump_pc, m_dump[0].pc);
        check("dump_inst", dump_inst, m_dump[0].inst);
        check("dump_wdata", dump_wdata, m_dump[0].wdata);
        check("dump_last", dump_last, m_dump.size() == 1);
      end else begin
        check("dump_last_idle", dump_last, 0);
      end
      if (stall_prev) begin
        check("stall_valid", dump_valid, 1);
        check("stall_pc", dump_pc, prev_pc);
        check("stall_inst", dump_inst, prev_inst);
        check("stall_wdata", dump_wdata, prev_wdata);
        check("stall_last", dump_last, prev_last);
      end
      stall_prev = dump_valid && !dump_ready;
      prev_pc = dump_pc; prev_inst = dump_inst; prev_wdata = dump_wdata; prev_last = dump_last;
      if (dump_valid && dump_ready) begin
        got_pc.push_back(dump_pc);
        got_last.push_back(dump_last);
      end
    end
  end

  // ---------------- stimulus ----------------
  bit pat[6] = '{1, 0, 0, 1, 0, 1};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] inst);
    retire_valid = 1; retire_pc = pc; retire_inst = inst; retire_wdata = pc ^ 32'hA5A5_0000;
    step();
    retire_valid = 0;
  endtask

  task automatic arm_pulse();
    arm = 1;
    step();
    arm = 0;
  endtask

  // Starts a dump and drains it; use_pat selects the stalling ready pattern
  task automatic run_dump(input bit use_pat);
    bit done;
    done = 0;
    got_pc.delete(); got_last.delete();
    dump_ready = 0;
    check("valid_before_start", dump_valid, 0);
    dump_start = 1;
    step();
    dump_start = 0;
    check("valid_1cyc_after_start", dump_valid, 1);
    for (int i = 0; i < 40; i++) begin
      dump_ready = (use_pat && i < 6) ? pat[i] : 1'b1;
      dump_start = (i == 1);
      step();
      dump_start = 0;
      if (!dump_valid) begin done = 1; break; end
    end
    check("dump_completes", done, 1);
    check("state_after_dump", state, 3);
    dump_ready = 0;
  endtask

  task automatic check_seq(input logic [31:0] base, input int n);
    check("dump_count", got_pc.size(), n);
    for (int k = 0; k < n && k < got_pc.size(); k++) begin
      check("dump_seq_pc", got_pc[k], base + 32'(4 * k));
      check("dump_seq_last", got_last[k], k == n - 1);
    end
  endtask

  logic [31:0] first_dump[$];

  initial begin
    // Reset with retire traffic present
    retire_valid = 1; retire_inst = 32'h003100B3;
    for (int k = 0; k < 4; k++) begin
      retire_pc = 32'(k * 4);
      step();
    end
    check("rst_state", state, 0);
    check("rst_fill", fill, 0);
    check("rst_dump_valid", dump_valid, 0);
    check("rst_cnt_r", cnt_r, 0);
    rst_n = 1;
    step(); step();
    check("idle_ignores_retire_fill", fill, 0);
    check("idle_ignores_retire_cnt", cnt_r, 0);
    retire_valid = 0;

    // dump_start with nothing recorded
    dump_start = 1; step(); dump_start = 0; step();
    check("idle_dump_start_valid", dump_valid, 0);
    check("idle_dump_start_state", state, 0);

    // arm together with a trigger-matching retire
    trig_en = 1; trig_pc = 32'h08;
    arm = 1; retire_valid = 1; retire_pc = 32'h08; retire_inst = 32'h13;
    step();
    arm = 0; retire_valid = 0;
    check("arm_retire_state", state, 1);
    check("arm_retire_fill", fill, 0);
    check("arm_retire_trig", trig_hit, 0);
    dump_start = 1; step(); dump_start = 0; step();
    check("armed_dump_start_valid", dump_valid, 0);
    check("armed_dump_start_state", state, 1);

    // Short trace, trigger at 0x08, freeze after 0x10
    arm_pulse();
    retire(32'h00, 32'h13); retire(32'h04, 32'h13);
    check("no_trig_yet", trig_hit, 0);
    retire(32'h08, 32'h13);
    check("trig_hit_08", trig_hit, 1);
    check("post_state", state, 2);
    retire(32'h0C, 32'h13); retire(32'h10, 32'h13);
    check("frozen_state", state, 3);
    check("frozen_fill5", fill, 5);
    retire(32'h14, 32'h13);
    check("frozen_ignores_fill", fill, 5);
    run_dump(0);
    check_seq(32'h00, 5);

    // Wrapped trace: 12 retires, trigger at 0x24
    arm_pulse();
    trig_pc = 32'h24;
    for (int k = 0; k < 12; k++) retire(32'(k * 4), 32'h0000_0013 + 32'(k << 20));
    check("wrap_state", state, 3);
    check("wrap_fill", fill, 8);
    run_dump(1);
    check_seq(32'h10, 8);
    first_dump = got_pc;
    run_dump(0);
    check_seq(32'h10, 8);
    check("redump_count", got_pc.size(), first_dump.size());
    for (int k = 0; k < first_dump.size() && k < got_pc.size(); k++)
      check("redump_same", got_pc[k], first_dump[k]);

    // Opcode classification and saturation
    trig_en = 0;
    arm_pulse();
    retire(32'h100, 32'h003100B3); retire(32'h104, 32'h403100B3);
    retire(32'h108, 32'h00208063); retire(32'h10C, 32'h000000EF);
    retire(32'h110, 32'h00100093); retire(32'h114, 32'h00012083);
    retire(32'h118, 32'h00112023); retire(32'h11C, 32'h00000000);
    check("cls_r", cnt_r, 2);
    check("cls_b", cnt_b, 1);
    check("cls_j", cnt_j, 1);
    check("cls_i", cnt_i, 1);
    check("cls_ld", cnt_ld, 1);
    check("cls_st", cnt_st, 1);
    check("cls_other", cnt_other, 1);
    check("cls_state", state, 1);
    arm_pulse();
    for (int k = 0; k < 20; k++) retire(32'(k * 4), 32'h003100B3);
    check("cnt_r_saturates", cnt_r, 15);
    check("fill_saturates", fill, 8);

    // Async reset in the middle of a stalled dump
    trig_en = 1; trig_pc = 32'h08;
    arm_pulse();
    for (int k = 0; k < 5; k++) retire(32'(k * 4), 32'h13);
    check("pre_rst_frozen", state, 3);
    dump_ready = 0;
    dump_start = 1; step(); dump_start = 0; step();
    check("pre_rst_valid", dump_valid, 1);
    rst_n = 0;
    #1;
    check("rst_mid_dump_valid", dump_valid, 0);
    check("rst_mid_dump_state", state, 0);
    check("rst_mid_dump_fill", fill, 0);
    step();
    rst_n = 1;
    step();
    check("post_rst_state", state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
